// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared button indices, arbiter states and helpers for the Simon game
package simon_pkg;

    localparam logic [1:0] BTN_0 = 2'd0;
    localparam logic [1:0] BTN_1 = 2'd1;
    localparam logic [1:0] BTN_2 = 2'd2;
    localparam logic [1:0] BTN_3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // Lowest set bit wins when several buttons land in the same cycle.
    function automatic logic [1:0] lowest_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = BTN_0;
        if (v[3]) idx = BTN_3;
        if (v[2]) idx = BTN_2;
        if (v[1]) idx = BTN_1;
        if (v[0]) idx = BTN_0;
        return idx;
    endfunction

endpackage

// File: rtl/simon_button_ctrl_if.sv
// rtl/simon_button_ctrl_if.sv - press handshake between the button front end and the game FSM
interface simon_button_ctrl_if;
    logic       tick_strobe;
    logic       btn_valid;
    logic [1:0] btn_val;
    logic       multi_press;
    logic       press_dropped;

    modport master (
        input  tick_strobe,
        output btn_valid,
        output btn_val,
        output multi_press,
        output press_dropped
    );

    modport slave (
        output tick_strobe,
        input  btn_valid,
        input  btn_val,
        input  multi_press,
        input  press_dropped
    );
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - one button: two-flop synchronizer, debounce counter, press edge
module button_debounce #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic stable,
    output logic rise
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic            meta;
    logic            sync;
    logic            stable_d;
    logic [DB_W-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= btn_raw;
            sync <= meta;
        end
    end

    // Flip the stable value only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

    assign rise = stable & ~stable_d;

endmodule

// File: rtl/simon_button_ctrl.sv
// rtl/simon_button_ctrl.sv - debounced button front end producing one press per hold for the game FSM
module simon_button_ctrl
    import simon_pkg::*;
#(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [3:0]                 btn_raw,
    simon_button_ctrl_if.master        bus
);

    logic [3:0] stable;
    logic [3:0] rise;

    arb_state_t state, state_nx;
    logic       valid_nx;
    logic [1:0] val_nx;
    logic       multi_nx;
    logic       drop_nx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            button_debounce #(
                .DB_CYCLES (DB_CYCLES),
                .DB_W      (DB_W)
            ) u_db (
                .clk     (clk),
                .reset_n (reset_n),
                .btn_raw (btn_raw[gi]),
                .stable  (stable[gi]),
                .rise    (rise[gi])
            );
        end
    endgenerate

    // Arbiter state and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            bus.btn_valid     <= 1'b0;
            bus.btn_val       <= BTN_0;
            bus.multi_press   <= 1'b0;
            bus.press_dropped <= 1'b0;
        end else begin
            state             <= state_nx;
            bus.btn_valid     <= valid_nx;
            bus.btn_val       <= val_nx;
            bus.multi_press   <= multi_nx;
            bus.press_dropped <= drop_nx;
        end
    end

    // Accept one press, hold it until the game tick takes it, then wait for all buttons up.
    always_comb begin
        state_nx = state;
        valid_nx = bus.btn_valid;
        val_nx   = bus.btn_val;
        multi_nx = 1'b0;
        drop_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                valid_nx = 1'b0;
                if (|rise) begin
                    val_nx   = lowest_index(rise);
                    valid_nx = 1'b1;
                    multi_nx = (rise & (rise - 4'd1)) != 4'd0;
                    state_nx = ST_PENDING;
                end
            end
            ST_PENDING: begin
                valid_nx = 1'b1;
                drop_nx  = |rise;
                if (bus.tick_strobe) begin
                    valid_nx = 1'b0;
                    state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                valid_nx = 1'b0;
                drop_nx  = |rise;
                if (stable == 4'd0) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                valid_nx = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_simon_button_ctrl.sv
// tb/tb_simon_button_ctrl.sv - directed and random checks of simon_button_ctrl against a behavioural model
module tb_simon_button_ctrl;

    localparam int DBC = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] btn_raw = 4'd0;

    simon_button_ctrl_if bus();

    simon_button_ctrl #(
        .DB_CYCLES (DBC),
        .DB_W      (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn_raw),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model: raw delay line, per-button disagreement run length, press bookkeeping.
    logic [3:0] m_p1, m_p2, m_stable, m_prev;
    int         m_run [4];
    bit         m_pend, m_rel, m_multi, m_drop;
    int         m_idx;

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_stable = 0; m_prev = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_pend = 0; m_rel = 0; m_multi = 0; m_drop = 0; m_idx = 0;
    endtask

    task automatic model_step();
        logic [3:0] rise, old_stable, sync;
        rise       = m_stable & ~m_prev;
        old_stable = m_stable;
        sync       = m_p2;
        for (int i = 0; i < 4; i++) begin
            if (sync[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == DBC) begin
                    m_stable[i] = sync[i];
                    m_run[i]    = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_prev = old_stable;
        m_p2   = m_p1;
        m_p1   = btn_raw;
        m_multi = 0;
        m_drop  = 0;
        if (m_pend) begin
            if (rise != 0) m_drop = 1;
            if (bus.tick_strobe) begin
                m_pend = 0;
                m_rel  = 1;
            end
        end else if (m_rel) begin
            if (rise != 0) m_drop = 1;
            if (old_stable == 0) m_rel = 0;
        end else if (rise != 0) begin
            m_pend  = 1;
            m_multi = ($countones(rise) > 1);
            for (int i = 3; i >= 0; i--) if (rise[i]) m_idx = i;
        end
    endtask

    int edge_no, first_valid, episodes, multi_cnt, drop_cnt, multi_at_rise;
    bit last_valid;

    task automatic clear_stats();
        edge_no = 0; first_valid = -1; episodes = 0;
        multi_cnt = 0; drop_cnt = 0; multi_at_rise = 0; last_valid = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step();
        edge_no++;
        @(negedge clk);
        check("btn_valid", bus.btn_valid, m_pend);
        if (m_pend) check("btn_val", bus.btn_val, m_idx);
        check("multi_press", bus.multi_press, m_multi);
        check("press_dropped", bus.press_dropped, m_drop);
        if (bus.btn_valid && !last_valid) begin
            episodes++;
            if (first_valid < 0) begin
                first_valid   = edge_no;
                multi_at_rise = bus.multi_press;
            end
        end
        last_valid = bus.btn_valid;
        multi_cnt += bus.multi_press;
        drop_cnt  += bus.press_dropped;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic restart(input logic [3:0] raw);
        reset_n = 1'b0;
        bus.tick_strobe = 1'b0;
        btn_raw = raw;
        model_reset();
        cycle();
        reset_n = 1'b1;
        clear_stats();
    endtask

    int ep0;

    initial begin
        bus.tick_strobe = 1'b0;
        model_reset();
        clear_stats();
        repeat (2) @(negedge clk);
        check("reset_valid", bus.btn_valid, 0);
        check("reset_val", bus.btn_val, 0);
        check("reset_multi", bus.multi_press, 0);
        check("reset_drop", bus.press_dropped, 0);

        // Single held button, consumed at cycle 15.
        restart(4'b0100);
        run(14);
        bus.tick_strobe = 1'b1;
        cycle();
        bus.tick_strobe = 1'b0;
        run(15);
        check("s1_first_valid", first_valid, 7);
        check("s1_episodes", episodes, 1);
        check("s1_valid_end", bus.btn_valid, 0);

        // Bouncing button 0, then held.
        restart(4'b0000);
        for (int e = 1; e <= 12; e++) begin
            btn_raw = {3'b000, (((e - 1) / 2) % 2) == 0};
            cycle();
        end
        btn_raw = 4'b0001;
        run(12);
        check("s2_first_valid", first_valid, 19);
        check("s2_episodes", episodes, 1);
        check("s2_val", bus.btn_val, 0);

        // Two buttons on the same edge.
        restart(4'b1010);
        run(10);
        check("s3_first_valid", first_valid, 7);
        check("s3_val", bus.btn_val, 1);
        check("s3_multi_at_rise", multi_at_rise, 1);
        check("s3_multi_cnt", multi_cnt, 1);
        check("s3_drop_cnt", drop_cnt, 0);

        // Press while pending is dropped; held button yields nothing after consumption.
        restart(4'b1000);
        run(8);
        check("s4_val3", bus.btn_val, 3);
        btn_raw = 4'b1001;
        run(10);
        check("s4_drop_cnt", drop_cnt, 1);
        check("s4_still_valid", bus.btn_valid, 1);
        check("s4_val_held", bus.btn_val, 3);
        bus.tick_strobe = 1'b1;
        cycle();
        bus.tick_strobe = 1'b0;
        ep0 = episodes;
        run(10);
        check("s4_no_repeat", episodes - ep0, 0);
        btn_raw = 4'b0000;
        run(10);
        btn_raw = 4'b0001;
        run(10);
        check("s4_new_valid", bus.btn_valid, 1);
        check("s4_new_val", bus.btn_val, 0);

        // Tick in IDLE on the rise cycle is ignored.
        restart(4'b0010);
        run(6);
        bus.tick_strobe = 1'b1;
        cycle();
        bus.tick_strobe = 1'b0;
        check("s5_valid_after_idle_tick", bus.btn_valid, 1);
        run(3);
        check("s5_valid_held", bus.btn_valid, 1);
        bus.tick_strobe = 1'b1;
        cycle();
        bus.tick_strobe = 1'b0;
        check("s5_consumed", bus.btn_valid, 0);

        // Asynchronous reset while pending, button kept held.
        restart(4'b0100);
        run(8);
        check("s6_pending", bus.btn_valid, 1);
        #2 reset_n = 1'b0;
        #1 check("s6_async_clear", bus.btn_valid, 0);
        model_reset();
        cycle();
        reset_n = 1'b1;
        clear_stats();
        run(30);
        check("s6_first_valid", first_valid, 7);
        check("s6_episodes", episodes, 1);
        check("s6_val", bus.btn_val, 2);

        // Random buttons, ticks and occasional resets against the model.
        restart(4'b0000);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(9) == 0) btn_raw[$urandom_range(3)] = ~btn_raw[$urandom_range(3)];
            if ($urandom_range(5) == 0) btn_raw = (btn_raw == 0) ? 4'($urandom_range(15)) : btn_raw;
            if ($urandom_range(30) == 0) btn_raw = 4'b0000;
            bus.tick_strobe = ($urandom_range(7) == 0);
            if ($urandom_range(600) == 0) begin
                restart(btn_raw);
            end else begin
                cycle();
            end
        end
        bus.tick_strobe = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
